fpu_addsub_seq: RTL and testbench
=================================

Name: fpu_addsub_seq

Overview:
- Multi-cycle, handshaked FP16 (1/5/10) add/subtract unit: the sequential responder for the FPU request stream.
- Accepts one operation per request; aligns and normalizes iteratively (1 bit/cycle); returns result plus ZCNV condition codes on a valid/ready response channel.
- Sits between the instruction front-end and the register writeback of the FPU datapath.

Parameters:
- BW, 16, total operand width
- EW, 5, exponent width
- SW, 10, stored significand width

Ports:
- clock  in  1  system clock, rising-edge
- reset_L  in  1  reset; asynchronous, active-low
- inValid  in  1  request valid
- inReady  out  1  unit can accept a request
- fpuIn1  in  BW  operand A
- fpuIn2  in  BW  operand B
- opSub  in  1  0 = A+B, 1 = A-B
- outValid  out  1  result valid
- outReady  in  1  consumer accepts result
- fpuOut  out  BW  result
- condCodes  out  4  {Z,C,N,V}

Behaviour:
- Reset (async, any state, including mid-operation): state = IDLE, inReady = 1, outValid = 0, fpuOut = 0, condCodes = 0. In-flight operation is discarded.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- inReady = 1 only in IDLE. Acceptance: inValid && inReady at a rising edge.
- On acceptance:
  - Unpack both operands: hidden bit 1 for normals; denormals use exponent 1 with hidden bit 0.
  - Effective sign of B = signB ^ opSub.
  - Swap so the larger magnitude ({exp,sig}) is the big operand.
  - Extended significand = hidden + 10 + guard/round/sticky (14 bits), plus a carry bit.
- Special cases go IDLE -> DONE directly, so outValid is asserted 1 cycle after acceptance:
  - Either operand NaN: result 16'h7E00, V = 1.
  - inf - inf (effective): result 16'h7E00, V = 1.
  - Any other case with an inf operand: result is that inf, V = 0.
  - Either operand ±0: result is the other operand, with the effective sign applied to B; -0 + -0 = -0.
- ALIGN, one cycle per step:
  - If exponent diff == 0, go to ADD.
  - Else if diff >= 14, collapse the small significand to sticky only and set diff = 0.
  - Else shift the small significand right 1, OR shifted-out bits into sticky, diff - 1.
- ADD (1 cycle):
  - Effective add: sum; C = carry out.
  - Effective subtract: big - small; C = 0.
- NORM, one cycle per step:
  - If carry set: shift right 1 (sticky preserved), exp + 1, then go to ROUND.
  - Else if MSB = 0 and exp > 1: shift left 1, exp - 1.
  - Else go to ROUND.
  - An exact zero goes straight to ROUND.
- ROUND (1 cycle):
  - Round-to-nearest-even on G/R/S.
  - If mantissa overflow, renormalize in the same cycle (exp + 1).
  - If exp >= 31: result = ±inf, V = 1.
  - Exact zero from cancellation gives +0.
  - Pack the result; Z = result magnitude is 0; N = result sign. Go to DONE.
- DONE:
  - outValid = 1; fpuOut and condCodes are held stable until outReady.
  - On outValid && outReady, go to IDLE. The next request can be accepted at the earliest on the following edge; no same-cycle accept.
- Latency, normal path (edges from acceptance to outValid): ALIGN cycles + 1 (ADD) + NORM cycles + 1 (ROUND) + 1.
  - ALIGN cycles = 1 for diff 0; diff + 1 for diff 1..13; 2 for diff >= 14.
  - NORM cycles >= 1.
- Output registers update only on entry to DONE or on reset.

Optional Feature:
- Macro: FPU_ADDSUB_FAST_ALIGN_EN.
- Defined: ALIGN uses a barrel shift with full sticky OR and always takes exactly 1 cycle. NORM still shifts 1 bit/cycle.
- Undefined: 1-bit/cycle alignment as described above.
- Results and condCodes are identical either way; only latency differs.

Test Plan:
- 3C00 + 0000, opSub = 0 -> fpuOut 3C00, ZCNV 0000, outValid 1 cycle after acceptance.
- 4000 + 3C00 -> 4200, ZCNV 0000, outValid 5 edges after acceptance (4 with FPU_ADDSUB_FAST_ALIGN_EN).
- 3C00 - 3C00 -> 0000, ZCNV 1000. Also 3C00 - 0000 -> 3C00, ZCNV 0000.
- 7BFF + 7BFF -> 7C00, ZCNV 0101. 7C00 - 7C00 -> 7E00, ZCNV 0001.
- Backpressure: outReady held low 5 cycles in DONE -> fpuOut/condCodes stable, inReady = 0, a second inValid is not accepted; accepted 1 cycle after the outReady handshake.
- Reset_L pulsed low during ALIGN of 4000 + 3C00 -> outputs 0 immediately (async), state IDLE, inReady = 1. A fresh 3C00 + 3C00 afterwards -> 4000.

Source files
------------

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle FP16 (1/5/10) add/subtract unit on a valid/ready
// request/response pair. Alignment and normalization advance one bit per cycle;
// results carry {Z,C,N,V} condition codes.
// Optional build macro FPU_ADDSUB_FAST_ALIGN_EN: alignment becomes a single-cycle
// barrel shift with full sticky collection. Results are identical; only latency
// changes.
module fpu_addsub_seq #(
  parameter int BW = 16,
  parameter int EW = 5,
  parameter int SW = 10
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          inValid,
  output logic          inReady,
  input  logic [BW-1:0] fpuIn1,
  input  logic [BW-1:0] fpuIn2,
  input  logic          opSub,
  output logic          outValid,
  input  logic          outReady,
  output logic [BW-1:0] fpuOut,
  output logic [3:0]    condCodes
);
  // Extended significand: hidden + fraction + guard/round/sticky.
  localparam int XW = SW + 4;
  // Working exponent carries headroom for the normalize and rounding increments.
  localparam int NW = EW + 1;
  localparam logic [EW-1:0] EMAX = '1;
  localparam logic [BW-1:0] QNAN = {1'b0, EMAX, 1'b1, {(SW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] out_q, out_d;
  logic [3:0]    cc_q, cc_d;
  logic          sign_q, sign_d;
  logic          eff_sub_q, eff_sub_d;
  logic          carry_q, carry_d;
  logic [NW-1:0] exp_q, exp_d;
  logic [NW-1:0] diff_q, diff_d;
  logic [XW:0]   big_q, big_d;
  logic [XW-1:0] small_q, small_d;

  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [SW-1:0] a_frac, b_frac;
  logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
  logic [NW-1:0] a_e, b_e;
  logic [SW:0]   a_m, b_m;
  logic          a_big;
  logic [BW-1:0] sp_res;
  logic          sp_v;
  logic [XW:0]   sum;
  logic [BW:0]   rp;

  // Round-to-nearest-even on G/R/S, renormalize a mantissa carry, pack.
  // Returns {overflow, packed result}.
  function automatic logic [BW:0] round_pack(input logic s, input logic [NW-1:0] e,
                                             input logic [XW-1:0] x);
    logic [SW+1:0] m;
    logic [NW-1:0] ex;
    logic          up;
    logic          ovf;
    logic [BW-1:0] r;
    up  = x[2] & (x[1] | x[0] | x[3]);
    m   = {1'b0, x[XW-1:3]} + {{(SW+1){1'b0}}, up};
    ex  = e;
    ovf = 1'b0;
    if (m[SW+1]) begin
      m  = m >> 1;
      ex = ex + NW'(1);
    end
    if (x == '0) begin
      r = '0;
    end else if (ex >= {1'b0, EMAX}) begin
      r   = {s, EMAX, {SW{1'b0}}};
      ovf = 1'b1;
    end else begin
      r = {s, (m[SW] ? ex[EW-1:0] : {EW{1'b0}}), m[SW-1:0]};
    end
    return {ovf, r};
  endfunction

`ifdef FPU_ADDSUB_FAST_ALIGN_EN
  // Single-step right shift by d; every bit shifted past bit 0 is ORed into sticky.
  function automatic logic [XW-1:0] align_shift(input logic [XW-1:0] x, input logic [NW-1:0] d);
    logic [XW-1:0] r;
    logic          st;
    st = 1'b0;
    for (int i = 0; i < XW; i++) begin
      if (i <= int'(d)) st = st | x[i];
    end
    r    = (d >= NW'(XW)) ? '0 : (x >> d);
    r[0] = r[0] | st;
    return r;
  endfunction
`endif

  // Operand unpack, magnitude compare and special-case resolution.
  always_comb begin
    a_sign = fpuIn1[BW-1];
    b_sign = fpuIn2[BW-1] ^ opSub;
    a_exp  = fpuIn1[BW-2:SW];
    b_exp  = fpuIn2[BW-2:SW];
    a_frac = fpuIn1[SW-1:0];
    b_frac = fpuIn2[SW-1:0];
    a_nan  = (a_exp == EMAX) && (a_frac != '0);
    b_nan  = (b_exp == EMAX) && (b_frac != '0);
    a_inf  = (a_exp == EMAX) && (a_frac == '0);
    b_inf  = (b_exp == EMAX) && (b_frac == '0);
    a_zero = (a_exp == '0) && (a_frac == '0);
    b_zero = (b_exp == '0) && (b_frac == '0);
    a_e    = (a_exp == '0) ? NW'(1) : {1'b0, a_exp};
    b_e    = (b_exp == '0) ? NW'(1) : {1'b0, b_exp};
    a_m    = {(a_exp != '0), a_frac};
    b_m    = {(b_exp != '0), b_frac};
    a_big  = {a_e, a_m} >= {b_e, b_m};
    is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sp_v   = 1'b0;
    sp_res = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      sp_res = QNAN;
      sp_v   = 1'b1;
    end else if (a_inf) begin
      sp_res = fpuIn1;
    end else if (b_inf) begin
      sp_res = {b_sign, fpuIn2[BW-2:0]};
    end else if (a_zero && b_zero) begin
      // Signed zero survives only when both effective signs are negative.
      sp_res = {a_sign & b_sign, {(BW-1){1'b0}}};
    end else if (a_zero) begin
      sp_res = {b_sign, fpuIn2[BW-2:0]};
    end else if (b_zero) begin
      sp_res = fpuIn1;
    end
  end

  assign sum = eff_sub_q ? (big_q - {1'b0, small_q}) : (big_q + {1'b0, small_q});
  assign rp  = round_pack(sign_q, exp_q, big_q[XW-1:0]);

  // Next-state and datapath updates for each FSM state.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cc_d      = cc_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    carry_d   = carry_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    big_d     = big_q;
    small_d   = small_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          if (is_special) begin
            out_d   = sp_res;
            cc_d    = {(sp_res[BW-2:0] == '0), 1'b0, sp_res[BW-1], sp_v};
            state_d = DONE;
          end else begin
            eff_sub_d = a_sign ^ b_sign;
            carry_d   = 1'b0;
            if (a_big) begin
              sign_d  = a_sign;
              exp_d   = a_e;
              diff_d  = a_e - b_e;
              big_d   = {1'b0, a_m, 3'b000};
              small_d = {b_m, 3'b000};
            end else begin
              sign_d  = b_sign;
              exp_d   = b_e;
              diff_d  = b_e - a_e;
              big_d   = {1'b0, b_m, 3'b000};
              small_d = {a_m, 3'b000};
            end
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
`ifdef FPU_ADDSUB_FAST_ALIGN_EN
        small_d = align_shift(small_q, diff_q);
        diff_d  = '0;
        state_d = ADD;
`else
        if (diff_q == '0) begin
          state_d = ADD;
        end else if (diff_q >= NW'(XW)) begin
          // Everything would fall off the end: only the sticky survives.
          small_d = {{(XW-1){1'b0}}, |small_q};
          diff_d  = '0;
        end else begin
          small_d = {1'b0, small_q[XW-1:2], |small_q[1:0]};
          diff_d  = diff_q - NW'(1);
        end
`endif
      end
      ADD: begin
        big_d   = sum;
        carry_d = ~eff_sub_q & sum[XW];
        state_d = NORM;
      end
      NORM: begin
        if (big_q[XW]) begin
          big_d   = {1'b0, big_q[XW:2], |big_q[1:0]};
          exp_d   = exp_q + NW'(1);
          state_d = ROUND;
        end else if ((big_q != '0) && !big_q[XW-1] && (exp_q > NW'(1))) begin
          big_d = big_q << 1;
          exp_d = exp_q - NW'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_d   = rp[BW-1:0];
        cc_d    = {(rp[BW-2:0] == '0), carry_q, rp[BW-1], rp[BW]};
        state_d = DONE;
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      out_q   <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cc_q    <= cc_d;
    end
  end

  // Working datapath registers; only meaningful while an operation is in flight.
  always_ff @(posedge clock) begin
    sign_q    <= sign_d;
    eff_sub_q <= eff_sub_d;
    carry_q   <= carry_d;
    exp_q     <= exp_d;
    diff_q    <= diff_d;
    big_q     <= big_d;
    small_q   <= small_d;
  end

  assign inReady   = (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign fpuOut    = out_q;
  assign condCodes = cc_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: scoreboard of expected results fed by the driver,
// drained by an independent output monitor. Reference results come from exact
// integer arithmetic on operand values (units of 2^-24) rounded to nearest-even.
module tb_fpu_addsub_seq;
  logic        clock = 1'b0;
  logic        reset_L;
  logic        inValid;
  logic        inReady;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic        opSub;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] fpuOut;
  logic [3:0]  condCodes;

  fpu_addsub_seq #(.BW(16), .EW(5), .SW(10)) dut (
    .clock(clock), .reset_L(reset_L),
    .inValid(inValid), .inReady(inReady),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .opSub(opSub),
    .outValid(outValid), .outReady(outReady),
    .fpuOut(fpuOut), .condCodes(condCodes)
  );

  always #5 clock = ~clock;

`ifdef FPU_ADDSUB_FAST_ALIGN_EN
  localparam int LAT_D1 = 4;
`else
  localparam int LAT_D1 = 5;
`endif

  typedef struct {
    logic [15:0] res;
    logic [3:0]  cc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc_cyc = 0;
  int   last_hs_cyc  = 0;
  bit   rand_bp = 1'b0;
  bit   force_ready = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, act, act, want, want, cyc);
    end
  endtask

  // Exact FP16 add/sub: operand values as integers in units of 2^-24.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                    output logic [15:0] r, output logic [3:0] cc);
    logic   sa, sbb, c, v, an, bn, ai, bi, az, bz, s;
    int     ea, eb, ebig, p, sh, e;
    longint fa, fb, va, vb, tot, mag, mant, rem, half;
    sa = a[15]; sbb = b[15] ^ sub;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = longint'(a[9:0]); fb = longint'(b[9:0]);
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    az = (ea == 0) && (fa == 0);  bz = (eb == 0) && (fb == 0);
    c = 1'b0; v = 1'b0; r = 16'h0000;
    if (an || bn || (ai && bi && (sa != sbb))) begin
      r = 16'h7E00; v = 1'b1;
    end else if (ai) r = a;
    else if (bi) r = {sbb, b[14:0]};
    else if (az && bz) r = {sa & sbb, 15'h0};
    else if (az) r = {sbb, b[14:0]};
    else if (bz) r = a;
    else begin
      va = (ea == 0) ? fa : ((1024 + fa) << (ea - 1));
      vb = (eb == 0) ? fb : ((1024 + fb) << (eb - 1));
      ebig = (ea == 0 ? 1 : ea) > (eb == 0 ? 1 : eb) ? (ea == 0 ? 1 : ea) : (eb == 0 ? 1 : eb);
      // Carry: magnitude sum reaches the binade above the larger operand's exponent.
      c = (sa == sbb) && ((va + vb) >= (64'sd1 <<< (ebig + 10)));
      tot = (sa ? -va : va) + (sbb ? -vb : vb);
      s   = (tot < 0);
      mag = s ? -tot : tot;
      if (mag == 0) r = 16'h0000;
      else if (mag < 2048) r = {s, 15'(mag)};
      else begin
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        sh   = p - 10;
        mant = mag >>> sh;
        rem  = mag & ((64'sd1 <<< sh) - 1);
        half = 64'sd1 <<< (sh - 1);
        if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 1;
        if (mant == 2048) begin mant = 1024; sh = sh + 1; end
        e = sh + 1;
        if (e >= 31) begin r = {s, 5'h1F, 10'h000}; v = 1'b1; end
        else r = {s, 5'(e), 10'(mant)};
      end
    end
    cc = {(r[14:0] == 15'h0), c, r[15], v};
  endfunction

  function automatic logic [15:0] rnd_op();
    int          k;
    logic [15:0] v;
    k = $urandom_range(0, 19);
    v = 16'($urandom);
    case (k)
      0:       v[14:0] = 15'h0000;
      1:       v[14:0] = 15'h7C00;
      2:       begin v[14:10] = 5'h1F; if (v[9:0] == 10'h000) v[9] = 1'b1; end
      3, 4:    v[14:10] = 5'h00;
      5:       v[14:10] = 5'h1E;
      default: if (v[14:10] == 5'h1F) v[14:10] = 5'h1E;
    endcase
    return v;
  endfunction

  // Present a request, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input int lat);
    exp_t x;
    int   g;
    fpuIn1 = a; fpuIn2 = b; opSub = s; inValid = 1'b1;
    g = 0;
    while (!inReady && g < 500) begin @(negedge clock); g++; end
    if (!inReady) begin
      check("accept_timeout", 0, 1);
      inValid = 1'b0;
      return;
    end
    ref_model(a, b, s, x.res, x.cc);
    x.lat = lat;
    x.acc = cyc + 1;
    last_acc_cyc = x.acc;
    sb.push_back(x);
    @(posedge clock); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin @(negedge clock); g++; end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  // Consumer-side ready: random backpressure or a forced level.
  initial begin
    forever begin
      @(posedge clock); #1;
      outReady = rand_bp ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  // Output monitor: latency at first valid, stability while held, compare on handshake.
  initial begin
    exp_t        cur;
    logic        was_valid;
    logic        unstable;
    logic [15:0] snap_out;
    logic [3:0]  snap_cc;
    int          lat;
    was_valid = 1'b0; unstable = 1'b0; snap_out = '0; snap_cc = '0; lat = 0;
    forever begin
      @(negedge clock);
      if (outValid) begin
        if (!was_valid) begin
          if (sb.size() == 0) check("unexpected_output", 1, 0);
          else begin
            lat = cyc - sb[0].acc;
            snap_out = fpuOut; snap_cc = condCodes; unstable = 1'b0;
          end
        end else if (fpuOut != snap_out || condCodes != snap_cc) begin
          unstable = 1'b1;
        end
        if (outReady && sb.size() != 0) begin
          cur = sb.pop_front();
          check("result", fpuOut, cur.res);
          check("zcnv", condCodes, cur.cc);
          if (cur.lat >= 0) check("latency", lat, cur.lat);
          check("held_stable", unstable, 0);
          last_hs_cyc = cyc + 1;
        end
      end
      was_valid = outValid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a, b;
    logic        s;
    int          k, g;
    reset_L = 1'b0; inValid = 1'b0; fpuIn1 = '0; fpuIn2 = '0; opSub = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_fpuOut", fpuOut, 0);
    check("rst_cc", condCodes, 0);
    check("rst_outValid", outValid, 0);
    check("rst_inReady", inReady, 1);
    reset_L = 1'b1;
    @(negedge clock);

    // Directed cases; latency = edges after the accepting edge until outValid.
    issue(16'h3C00, 16'h0000, 1'b0, 0);      wait_drain();
    issue(16'h4000, 16'h3C00, 1'b0, LAT_D1); wait_drain();
    issue(16'h3C00, 16'h3C00, 1'b1, 4);      wait_drain();
    issue(16'h3C00, 16'h0000, 1'b1, 0);      wait_drain();
    issue(16'h7BFF, 16'h7BFF, 1'b0, 4);      wait_drain();
    issue(16'h7C00, 16'h7C00, 1'b1, 0);      wait_drain();
    issue(16'h8000, 16'h8000, 1'b0, 0);      wait_drain();
    issue(16'h0001, 16'h8002, 1'b0, -1);     wait_drain();
    issue(16'h3C00, 16'h0001, 1'b1, -1);     wait_drain();

    // Backpressure: result held while outReady is low, second request waits.
    force_ready = 1'b0;
    @(posedge clock); #2;
    issue(16'h4000, 16'h3C00, 1'b0, LAT_D1);
    fork
      issue(16'h3C00, 16'h3C00, 1'b0, 4);
      begin
        g = 0;
        while (!outValid && g < 100) begin @(negedge clock); g++; end
        check("bp_done_reached", outValid, 1);
        repeat (5) begin
          @(negedge clock);
          check("bp_inReady_low", inReady, 0);
          check("bp_outValid_held", outValid, 1);
        end
        force_ready = 1'b1;
      end
    join
    check("accept_after_handshake", last_acc_cyc, last_hs_cyc + 1);
    wait_drain();

    // Asynchronous reset while aligning: operation dropped, outputs cleared at once.
    issue(16'h4000, 16'h3C00, 1'b0, -1);
    #2 reset_L = 1'b0;
    #1;
    check("async_rst_fpuOut", fpuOut, 0);
    check("async_rst_cc", condCodes, 0);
    check("async_rst_outValid", outValid, 0);
    check("async_rst_inReady", inReady, 1);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    issue(16'h3C00, 16'h3C00, 1'b0, 4);
    wait_drain();

    // Randomized operands with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = rnd_op(); b = rnd_op(); s = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 5);
      if (k == 0) begin
        b = a ^ 16'($urandom_range(0, 7)); s = 1'b1;
      end else if (k == 1) begin
        b = {~a[15], a[14:10], 10'($urandom)}; s = 1'b0;
      end
      issue(a, b, s, -1);
    end
    rand_bp = 1'b0;
    force_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
